// File: rtl/ps2_bus_pkg.sv
// Shared definitions for the PS/2 bus controller: register map, bus FSM states
// and STATUS/CONTROL bit positions.
package ps2_bus_pkg;

    localparam logic [1:0] AddrData   = 2'd0;
    localparam logic [1:0] AddrStatus = 2'd1;
    localparam logic [1:0] AddrCtrl   = 2'd2;
    localparam logic [1:0] AddrNone   = 2'd3;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StDecode = 2'd1,
        StAck    = 2'd2
    } bus_state_e;

    localparam logic [2:0] StatRxValid = 3'd0;
    localparam logic [2:0] StatTxBusy  = 3'd1;
    localparam logic [2:0] StatRxOvr   = 3'd2;
    localparam logic [2:0] StatTxErr   = 3'd3;
    localparam logic [2:0] StatIrq     = 3'd4;

    localparam logic CtrlRxIe = 1'b0;
    localparam logic CtrlTxIe = 1'b1;

endpackage

// File: rtl/cpu_bus_fsm.sv
// CPU bus handshake: IDLE -> DECODE -> ACK -> IDLE, latching the request and
// emitting a one-cycle access strobe while in DECODE.
module cpu_bus_fsm
    import ps2_bus_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cs,
    input  logic       ds,
    input  logic       rw,
    input  logic [1:0] addr,
    input  logic [7:0] wdata,
    output logic       access,
    output logic [1:0] acc_addr,
    output logic       acc_rw,
    output logic [7:0] acc_wdata,
    output logic       dtack,
    output logic       oe
);

    bus_state_e state_q, state_d;
    logic       dtack_q, dtack_d;
    logic       oe_q, oe_d;
    logic       latch;
    logic       sel;

    assign sel = cs && ds;

    always_comb begin
        state_d = state_q;
        dtack_d = dtack_q;
        oe_d    = oe_q;
        access  = 1'b0;
        latch   = 1'b0;
        unique case (state_q)
            StIdle: begin
                dtack_d = 1'b1;
                oe_d    = 1'b0;
                if (sel) begin
                    latch   = 1'b1;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                access  = 1'b1;
                dtack_d = 1'b0;
                oe_d    = acc_rw;
                state_d = StAck;
            end
            StAck: begin
                // Only a strobe release lets the FSM rearm; holding cs&&ds stays here.
                if (!sel) begin
                    dtack_d = 1'b1;
                    oe_d    = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            dtack_q   <= 1'b1;
            oe_q      <= 1'b0;
            acc_addr  <= 2'd0;
            acc_rw    <= 1'b0;
            acc_wdata <= 8'h00;
        end else begin
            state_q <= state_d;
            dtack_q <= dtack_d;
            oe_q    <= oe_d;
            if (latch) begin
                acc_addr  <= addr;
                acc_rw    <= rw;
                acc_wdata <= wdata;
            end
        end
    end

    assign dtack = dtack_q;
    assign oe    = oe_q;

endmodule

// File: rtl/ps2_bus_ctrl.sv
// PS/2 controller CPU-bus register block (DATA, STATUS, CONTROL).
// Define PS2_BUS_IRQ_EN to enable the CONTROL enables and the irq output.
module ps2_bus_ctrl
    import ps2_bus_pkg::*;
#(
    parameter logic [7:0] RESET_CTRL = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cs,
    input  logic       ds,
    input  logic       rw,
    input  logic [1:0] addr,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic       uio_oe,
    output logic       dtack,
    input  logic [7:0] rx_data,
    input  logic       rx_strobe,
    input  logic       tx_busy,
    output logic [7:0] tx_data,
    output logic       tx_start,
    output logic       irq
);

    logic       access;
    logic [1:0] acc_addr;
    logic       acc_rw;
    logic [7:0] acc_wdata;

    cpu_bus_fsm u_fsm (
        .clk       (clk),
        .rst_n     (rst_n),
        .cs        (cs),
        .ds        (ds),
        .rw        (rw),
        .addr      (addr),
        .wdata     (uio_in),
        .access    (access),
        .acc_addr  (acc_addr),
        .acc_rw    (acc_rw),
        .acc_wdata (acc_wdata),
        .dtack     (dtack),
        .oe        (uio_oe)
    );

    logic [7:0] rx_buf_q, rx_buf_d;
    logic       rx_valid_q, rx_valid_d;
    logic       rx_ovr_q, rx_ovr_d;
    logic       tx_err_q, tx_err_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic       tx_start_q, tx_start_d;
    logic [7:0] uio_out_q, uio_out_d;
    logic       irq_q, irq_d;
    logic [1:0] ctrl_rd;
    logic [7:0] status;
    logic [7:0] rdata;
    logic       rd_data, wr_data, rd_stat, wr_ctrl;

    assign rd_data = access && acc_rw && (acc_addr == AddrData);
    assign wr_data = access && !acc_rw && (acc_addr == AddrData);
    assign rd_stat = access && acc_rw && (acc_addr == AddrStatus);
    assign wr_ctrl = access && !acc_rw && (acc_addr == AddrCtrl);

    always_comb begin
        status              = 8'h00;
        status[StatRxValid] = rx_valid_q;
        status[StatTxBusy]  = tx_busy;
        status[StatRxOvr]   = rx_ovr_q;
        status[StatTxErr]   = tx_err_q;
        status[StatIrq]     = irq_q;
    end

    always_comb begin
        rdata = 8'h00;
        unique case (acc_addr)
            AddrData:   rdata = rx_buf_q;
            AddrStatus: rdata = status;
            AddrCtrl:   rdata = {6'b0, ctrl_rd};
            AddrNone:   rdata = 8'h00;
            default:    rdata = 8'h00;
        endcase
    end

    always_comb begin
        rx_buf_d   = rx_buf_q;
        rx_valid_d = rx_valid_q;
        rx_ovr_d   = rx_ovr_q;
        tx_err_d   = tx_err_q;
        tx_data_d  = tx_data_q;
        tx_start_d = wr_data && !tx_busy;
        uio_out_d  = access ? rdata : uio_out_q;
        if (rd_data) rx_valid_d = 1'b0;
        if (rd_stat) begin
            rx_ovr_d = 1'b0;
            tx_err_d = 1'b0;
        end
        // A byte arriving during a DATA read replaces the one being returned.
        if (rx_strobe) begin
            if (!rx_valid_q || rd_data) begin
                rx_buf_d   = rx_data;
                rx_valid_d = 1'b1;
            end else begin
                rx_ovr_d = 1'b1;
            end
        end
        if (wr_data) begin
            tx_data_d = acc_wdata;
            if (tx_busy) tx_err_d = 1'b1;
        end
    end

`ifdef PS2_BUS_IRQ_EN
    logic [1:0] ctrl_q, ctrl_d;

    assign ctrl_d  = wr_ctrl ? acc_wdata[1:0] : ctrl_q;
    assign ctrl_rd = ctrl_q;
    assign irq_d   = (ctrl_d[CtrlRxIe] && rx_valid_d) || (ctrl_d[CtrlTxIe] && tx_err_d);

    always_ff @(posedge clk) begin
        if (!rst_n) ctrl_q <= RESET_CTRL[1:0];
        else        ctrl_q <= ctrl_d;
    end
`else
    logic unused_cfg;

    assign ctrl_rd    = 2'b00;
    assign irq_d      = 1'b0;
    assign unused_cfg = ^{RESET_CTRL, wr_ctrl};
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_buf_q   <= 8'h00;
            rx_valid_q <= 1'b0;
            rx_ovr_q   <= 1'b0;
            tx_err_q   <= 1'b0;
            tx_data_q  <= 8'h00;
            tx_start_q <= 1'b0;
            uio_out_q  <= 8'h00;
            irq_q      <= 1'b0;
        end else begin
            rx_buf_q   <= rx_buf_d;
            rx_valid_q <= rx_valid_d;
            rx_ovr_q   <= rx_ovr_d;
            tx_err_q   <= tx_err_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            uio_out_q  <= uio_out_d;
            irq_q      <= irq_d;
        end
    end

    assign uio_out  = uio_out_q;
    assign tx_data  = tx_data_q;
    assign tx_start = tx_start_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_ps2_bus_ctrl.sv
// Directed self-checking bench for ps2_bus_ctrl; inputs driven and outputs
// sampled on the falling clock edge.
module tb_ps2_bus_ctrl;

    logic       clk;
    logic       rst_n;
    logic       cs;
    logic       ds;
    logic       rw;
    logic [1:0] addr;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic       uio_oe;
    logic       dtack;
    logic [7:0] rx_data;
    logic       rx_strobe;
    logic       tx_busy;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       irq;

    int passed = 0;
    int total  = 0;
    int tx_pulses = 0;

    ps2_bus_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cs        (cs),
        .ds        (ds),
        .rw        (rw),
        .addr      (addr),
        .uio_in    (uio_in),
        .uio_out   (uio_out),
        .uio_oe    (uio_oe),
        .dtack     (dtack),
        .rx_data   (rx_data),
        .rx_strobe (rx_strobe),
        .tx_busy   (tx_busy),
        .tx_data   (tx_data),
        .tx_start  (tx_start),
        .irq       (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (tx_start === 1'b1) tx_pulses++;

    // Full bus cycle; returns the byte seen while dtack is low.
    task automatic bus_access(input logic r, input logic [1:0] a, input logic [7:0] wd,
                              output logic [7:0] rd);
        int n;
        @(negedge clk);
        cs = 1'b1; ds = 1'b1; rw = r; addr = a; uio_in = wd;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (dtack !== 1'b0 && n < 8);
        total++;
        if (dtack !== 1'b0) $display("FAIL dtack_timeout addr=%0d got dtack=%b want 0", a, dtack);
        else passed++;
        rd = uio_out;
        cs = 1'b0; ds = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_rx(input logic [7:0] d);
        @(negedge clk);
        rx_strobe = 1'b1; rx_data = d;
        @(negedge clk);
        rx_strobe = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] rd;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({dtack, uio_oe, uio_out, tx_start, tx_data, irq} !== {1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0})
            $display("FAIL reset_outputs got dtack=%b oe=%b out=%h start=%b txd=%h irq=%b",
                     dtack, uio_oe, uio_out, tx_start, tx_data, irq);
        else passed++;
        rst_n = 1'b1;
        bus_access(1'b1, 2'd1, 8'h00, rd);
        total++;
        if (rd !== 8'h00) $display("FAIL reset_status got %h want 00", rd);
        else passed++;
        bus_access(1'b1, 2'd2, 8'h00, rd);
        total++;
        if (rd !== 8'h00) $display("FAIL reset_ctrl got %h want 00", rd);
        else passed++;
    endtask

    task automatic test_rx_read();
        logic [7:0] rd;
        pulse_rx(8'hA5);
        @(negedge clk);
        cs = 1'b1; ds = 1'b1; rw = 1'b1; addr = 2'd0;
        @(negedge clk);
        total++;
        if (dtack !== 1'b1) $display("FAIL rx_read_dtack_1clk got %b want 1", dtack);
        else passed++;
        @(negedge clk);
        total++;
        if ({dtack, uio_oe, uio_out} !== {1'b0, 1'b1, 8'hA5})
            $display("FAIL rx_read_ack got dtack=%b oe=%b out=%h want 0 1 a5", dtack, uio_oe, uio_out);
        else passed++;
        cs = 1'b0; ds = 1'b0;
        @(negedge clk);
        total++;
        if ({dtack, uio_oe} !== 2'b10) $display("FAIL rx_read_release got %b%b want 10", dtack, uio_oe);
        else passed++;
        bus_access(1'b1, 2'd1, 8'h00, rd);
        total++;
        if (rd[0] !== 1'b0) $display("FAIL rx_read_valid_clr got %b want 0", rd[0]);
        else passed++;
    endtask

    task automatic test_overrun();
        logic [7:0] rd;
        pulse_rx(8'h11);
        pulse_rx(8'h22);
        bus_access(1'b1, 2'd0, 8'h00, rd);
        total++;
        if (rd !== 8'h11) $display("FAIL ovr_data got %h want 11", rd);
        else passed++;
        bus_access(1'b1, 2'd1, 8'h00, rd);
        total++;
        if (rd !== 8'h04) $display("FAIL ovr_status1 got %h want 04", rd);
        else passed++;
        bus_access(1'b1, 2'd1, 8'h00, rd);
        total++;
        if (rd !== 8'h00) $display("FAIL ovr_status2 got %h want 00", rd);
        else passed++;
    endtask

    task automatic test_same_cycle();
        logic [7:0] rd;
        pulse_rx(8'h44);
        @(negedge clk);
        cs = 1'b1; ds = 1'b1; rw = 1'b1; addr = 2'd0;
        @(negedge clk);
        rx_strobe = 1'b1; rx_data = 8'h99;
        @(negedge clk);
        rx_strobe = 1'b0;
        total++;
        if (uio_out !== 8'h44) $display("FAIL same_cycle_old got %h want 44", uio_out);
        else passed++;
        cs = 1'b0; ds = 1'b0;
        @(negedge clk);
        bus_access(1'b1, 2'd1, 8'h00, rd);
        total++;
        if (rd !== 8'h01) $display("FAIL same_cycle_status got %h want 01", rd);
        else passed++;
        bus_access(1'b1, 2'd0, 8'h00, rd);
        total++;
        if (rd !== 8'h99) $display("FAIL same_cycle_new got %h want 99", rd);
        else passed++;
    endtask

    task automatic test_tx();
        logic [7:0] rd;
        int p0;
        tx_busy = 1'b0;
        p0 = tx_pulses;
        bus_access(1'b0, 2'd0, 8'h5A, rd);
        repeat (2) @(negedge clk);
        total++;
        if (tx_data !== 8'h5A) $display("FAIL tx_data got %h want 5a", tx_data);
        else passed++;
        total++;
        if (tx_pulses - p0 != 1) $display("FAIL tx_start_count got %0d want 1", tx_pulses - p0);
        else passed++;
        tx_busy = 1'b1;
        p0 = tx_pulses;
        bus_access(1'b0, 2'd0, 8'h33, rd);
        repeat (2) @(negedge clk);
        total++;
        if (tx_pulses - p0 != 0) $display("FAIL tx_busy_start got %0d want 0", tx_pulses - p0);
        else passed++;
        bus_access(1'b1, 2'd1, 8'h00, rd);
        total++;
        if (rd !== 8'h0A) $display("FAIL tx_err_status got %h want 0a", rd);
        else passed++;
        tx_busy = 1'b0;
        bus_access(1'b1, 2'd1, 8'h00, rd);
        total++;
        if (rd !== 8'h00) $display("FAIL tx_err_clear got %h want 00", rd);
        else passed++;
    endtask

    task automatic test_hold();
        logic [7:0] rd;
        int lows;
        pulse_rx(8'h77);
        @(negedge clk);
        cs = 1'b1; ds = 1'b1; rw = 1'b1; addr = 2'd0;
        lows = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (i >= 2 && dtack === 1'b0) lows++;
            if (i == 4) begin
                rx_strobe = 1'b1; rx_data = 8'h88;
            end
            if (i == 5) rx_strobe = 1'b0;
        end
        total++;
        if (lows != 9) $display("FAIL hold_dtack_low got %0d cycles want 9", lows);
        else passed++;
        total++;
        if (uio_out !== 8'h77) $display("FAIL hold_data got %h want 77", uio_out);
        else passed++;
        cs = 1'b0; ds = 1'b0;
        @(negedge clk);
        total++;
        if ({dtack, uio_oe} !== 2'b10) $display("FAIL hold_release got %b%b want 10", dtack, uio_oe);
        else passed++;
        bus_access(1'b1, 2'd1, 8'h00, rd);
        total++;
        if (rd !== 8'h01) $display("FAIL hold_single_clear got %h want 01", rd);
        else passed++;
        bus_access(1'b1, 2'd0, 8'h00, rd);
        total++;
        if (rd !== 8'h88) $display("FAIL hold_next_byte got %h want 88", rd);
        else passed++;
    endtask

    task automatic test_addr3();
        logic [7:0] rd;
        bus_access(1'b0, 2'd3, 8'hFF, rd);
        bus_access(1'b1, 2'd3, 8'h00, rd);
        total++;
        if (rd !== 8'h00) $display("FAIL addr3_read got %h want 00", rd);
        else passed++;
    endtask

    task automatic test_ctrl_irq();
        logic [7:0] rd;
`ifdef PS2_BUS_IRQ_EN
        bus_access(1'b0, 2'd2, 8'h01, rd);
        bus_access(1'b1, 2'd2, 8'h00, rd);
        total++;
        if (rd !== 8'h01) $display("FAIL ctrl_read got %h want 01", rd);
        else passed++;
        pulse_rx(8'h3C);
        total++;
        if (irq !== 1'b1) $display("FAIL irq_set got %b want 1", irq);
        else passed++;
        bus_access(1'b1, 2'd0, 8'h00, rd);
        total++;
        if (irq !== 1'b0) $display("FAIL irq_clear got %b want 0", irq);
        else passed++;
        bus_access(1'b0, 2'd2, 8'h00, rd);
`else
        bus_access(1'b0, 2'd2, 8'hFF, rd);
        bus_access(1'b1, 2'd2, 8'h00, rd);
        total++;
        if (rd !== 8'h00) $display("FAIL ctrl_read got %h want 00", rd);
        else passed++;
        pulse_rx(8'h3C);
        total++;
        if (irq !== 1'b0) $display("FAIL irq_tied got %b want 0", irq);
        else passed++;
        bus_access(1'b1, 2'd0, 8'h00, rd);
        total++;
        if (rd !== 8'h3C) $display("FAIL ctrl_rx_drain got %h want 3c", rd);
        else passed++;
`endif
    endtask

    task automatic test_reset_mid();
        logic [7:0] rd;
        pulse_rx(8'h55);
        pulse_rx(8'h66);
        tx_busy = 1'b1;
        bus_access(1'b0, 2'd0, 8'h12, rd);
        tx_busy = 1'b0;
        @(negedge clk);
        cs = 1'b1; ds = 1'b1; rw = 1'b1; addr = 2'd0;
        repeat (2) @(negedge clk);
        total++;
        if (dtack !== 1'b0) $display("FAIL rst_mid_in_ack got %b want 0", dtack);
        else passed++;
        rst_n = 1'b0;
        @(negedge clk);
        total++;
        if ({dtack, uio_oe} !== 2'b10) $display("FAIL rst_mid_release got %b%b want 10", dtack, uio_oe);
        else passed++;
        rst_n = 1'b1;
        cs = 1'b0; ds = 1'b0;
        @(negedge clk);
        bus_access(1'b1, 2'd1, 8'h00, rd);
        total++;
        if (rd !== 8'h00) $display("FAIL rst_mid_status got %h want 00", rd);
        else passed++;
    endtask

    initial begin
        rst_n = 1'b0; cs = 1'b0; ds = 1'b0; rw = 1'b0; addr = 2'd0; uio_in = 8'h00;
        rx_data = 8'h00; rx_strobe = 1'b0; tx_busy = 1'b0;
        test_reset();
        test_rx_read();
        test_overrun();
        test_same_cycle();
        test_tx();
        test_hold();
        test_addr3();
        test_ctrl_irq();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/ps2_bus_ctrl.md
PS2_BUS_CTRL -- requirements
Module: ps2_bus_ctrl

Interface
REQ-001 SHALL have parameter RESET_CTRL, default 8'h00, meaning the CONTROL register value after reset.
REQ-002 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port cs  input  1  chip select, active high.
REQ-005 SHALL have port ds  input  1  data strobe, active high.
REQ-006 SHALL have port rw  input  1  1 = read, 0 = write.
REQ-007 SHALL have port addr  input  2  register select.
REQ-008 SHALL have port uio_in  input  8  CPU write data.
REQ-009 SHALL have port uio_out  output  8  CPU read data.
REQ-010 SHALL have port uio_oe  output  1  read-data drive enable.
REQ-011 SHALL have port dtack  output  1  data acknowledge, active low.
REQ-012 SHALL have port rx_data  input  8  received PS/2 byte.
REQ-013 SHALL have port rx_strobe  input  1  one-cycle pulse; rx_data is valid.
REQ-014 SHALL have port tx_busy  input  1  PS/2 transmitter busy.
REQ-015 SHALL have port tx_data  output  8  byte to transmit.
REQ-016 SHALL have port tx_start  output  1  one-cycle transmit request.
REQ-017 SHALL have port irq  output  1  interrupt request, active high.

Function
REQ-018 SHALL sequence bus cycles with FSM IDLE -> DECODE -> ACK -> IDLE.
REQ-019 SHALL, in IDLE with cs&&ds sampled high, latch addr, rw and uio_in, then enter DECODE.
REQ-020 SHALL, in DECODE, perform the access exactly once, load uio_out and set uio_oe=rw, then enter ACK.
REQ-021 SHALL hold dtack=0 in ACK while cs&&ds is high; on deassertion SHALL drive dtack=1 and uio_oe=0 and return to IDLE.
REQ-022 SHALL assert dtack two clocks after the strobe edge is sampled; in IDLE and DECODE dtack=1.
REQ-023 SHALL map addr 0 to DATA: read returns rx_buf and clears rx_valid; write latches tx_data.
REQ-024 SHALL, on a DATA write, pulse tx_start for one cycle when tx_busy=0; when tx_busy=1 it SHALL set tx_err and SHALL NOT pulse tx_start.
REQ-025 SHALL map addr 1 to STATUS, read-only: bit0 rx_valid, bit1 tx_busy, bit2 rx_ovr, bit3 tx_err, bit4 irq, bits7:5 zero; a STATUS read clears rx_ovr and tx_err after sampling them.
REQ-026 SHALL map addr 2 to CONTROL, read/write: bit0 rx_ie, bit1 tx_ie, bits7:2 read as zero.
REQ-027 SHALL make addr 3 read 8'h00 and ignore writes; dtack still completes.
REQ-028 SHALL, on rx_strobe with rx_valid=0, load rx_buf and set rx_valid.
REQ-029 SHALL, on rx_strobe with rx_valid=1, set rx_ovr and drop the new byte.
REQ-030 SHALL, when rx_strobe and a DATA read fall in the same DECODE cycle, return the old byte, load the new byte, leave rx_valid=1 and not set rx_ovr.
REQ-031 SHALL ignore a new strobe until the FSM has returned to IDLE, i.e. cs&&ds held high never re-triggers an access.

Reset
REQ-032 SHALL set on rst_n=0 at a clock edge: state IDLE, dtack=1, uio_oe=0, uio_out=8'h00, tx_start=0, tx_data=8'h00, irq=0, rx_valid=0, rx_ovr=0, tx_err=0, CONTROL=RESET_CTRL.
REQ-033 SHALL, on reset mid-cycle, abort the access with no side effects and release dtack in that cycle.

Configuration
REQ-034 SHALL, with PS2_BUS_IRQ_EN defined, register irq = (rx_ie&&rx_valid) || (tx_ie&&tx_err).
REQ-035 SHALL, without PS2_BUS_IRQ_EN, tie irq to 0, make CONTROL bits1:0 read 0 and ignore writes to them.

Structure
REQ-036 SHALL define in package ps2_bus_pkg: register address constants, FSM state encoding, and STATUS/CONTROL bit positions.
REQ-037 SHALL place the handshake FSM (REQ-018..022, REQ-031) in sub-module cpu_bus_fsm, which outputs a one-cycle access strobe.

Verification
REQ-038 SHALL cover: rx_strobe with rx_data=8'hA5, then a DATA read -> uio_out=8'hA5, uio_oe=1, dtack low 2 clocks after strobe, then STATUS bit0=0.
REQ-039 SHALL cover: two rx_strobes (8'h11, 8'h22) with no read -> DATA read=8'h11; STATUS=8'h04 on first read, 8'h00 on second.
REQ-040 SHALL cover: a DATA write of 8'h5A with tx_busy=0 -> tx_data=8'h5A and exactly one tx_start pulse; with tx_busy=1 -> no pulse and STATUS bit3=1.
REQ-041 SHALL cover: cs&&ds held 10 clocks on a DATA read -> a single rx_valid clear, dtack low until release, then dtack=1 and uio_oe=0.
REQ-042 SHALL cover: rst_n=0 while in ACK -> dtack=1, uio_oe=0 next edge, all status bits 0.
REQ-043 SHALL cover: with PS2_BUS_IRQ_EN defined, CONTROL write 8'h01 and then rx_strobe -> irq=1; a DATA read then gives irq=0.
